// File: rtl/scan_latch_pkg.sv
// Shared types for the scan-loaded latch bank: controller states and counter sizing.
package scan_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One extra bit so TOTAL itself is representable, and TOTAL=1 still gets a 1-bit counter.
  function automatic int cnt_width(input int total);
    return $clog2(total) + 1;
  endfunction

endpackage

// File: rtl/scan_latch_cell.sv
// One channel of level-sensitive configuration storage: transparent while i_en is high,
// holds otherwise; i_rst forces RESET_VAL asynchronously.
module scan_latch_cell #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_latch begin
    if (i_rst) begin
      o_q <= RESET_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/scan_latch_bank.sv
// Serial scan loader for NUM_CH x WIDTH config latches: io_q updates one cycle after the last bit,
// io_done pulses the cycle after that; no backpressure. Optional readback capture: SCAN_LATCH_CAPTURE_EN.
module scan_latch_bank
  import scan_latch_pkg::*;
#(
  parameter int                      WIDTH     = 8,
  parameter int                      NUM_CH    = 4,
  parameter logic [WIDTH*NUM_CH-1:0] RESET_VAL = '0
) (
  input  logic                    io_clk,
  input  logic                    io_reset,
  input  logic                    io_start,
  input  logic                    io_abort,
  input  logic                    io_scan_in,
  output logic                    io_scan_out,
  output logic                    io_busy,
  output logic                    io_done,
  output logic [WIDTH*NUM_CH-1:0] io_q
);

  localparam int               TOTAL = WIDTH * NUM_CH;
  localparam int               CNT_W = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_shift_en;
  logic [CNT_W-1:0]   r_cnt;
  logic [TOTAL-1:0]   r_sreg;
  logic [TOTAL-1:0]   w_sreg_shift;
  logic               r_latch_en;

  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort wins over the last-bit transition; no shift happens on the abort edge.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_start) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (io_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift_en = 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  if (TOTAL == 1) begin : g_one_bit
    assign w_sreg_shift = io_scan_in;
  end else begin : g_multi_bit
    assign w_sreg_shift = {r_sreg[TOTAL-2:0], io_scan_in};
  end

  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      r_cnt      <= '0;
      r_sreg     <= RESET_VAL;
      r_latch_en <= 1'b0;
    end else begin
      r_latch_en <= (w_state_nxt == ST_UPDATE);
      if (r_state == ST_IDLE && io_start) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_shift_en) begin
        r_sreg <= w_sreg_shift;
      end
`ifdef SCAN_LATCH_CAPTURE_EN
      else if (r_state == ST_IDLE && io_start) begin
        r_sreg <= io_q;
      end
`endif
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    scan_latch_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL[c*WIDTH +: WIDTH])
    ) u_cell (
      .i_rst (io_reset),
      .i_en  (r_latch_en),
      .i_d   (r_sreg[c*WIDTH +: WIDTH]),
      .o_q   (io_q[c*WIDTH +: WIDTH])
    );
  end

  assign io_scan_out = r_sreg[TOTAL-1];
  assign io_busy     = (r_state == ST_SHIFT) || (r_state == ST_UPDATE);
  assign io_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_scan_latch_bank.sv
// Directed bench for scan_latch_bank at default parameters (32-bit bank).
module tb_scan_latch_bank;

  logic        io_clk;
  logic        io_reset;
  logic        io_start;
  logic        io_abort;
  logic        io_scan_in;
  logic        io_scan_out;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_q;

`ifdef SCAN_LATCH_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  scan_latch_bank dut (
    .io_clk      (io_clk),
    .io_reset    (io_reset),
    .io_start    (io_start),
    .io_abort    (io_abort),
    .io_scan_in  (io_scan_in),
    .io_scan_out (io_scan_out),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_q        (io_q)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] exp_q;
    logic        exp_so;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] model_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the start edge (state SHIFT).
  task automatic begin_load();
    io_start = 1'b1;
    @(negedge io_clk);
    io_start = 1'b0;
  endtask

  // Shifts all 32 bits; returns at the negedge of the UPDATE cycle.
  task automatic shift_in(input logic [31:0] d, input logic [31:0] qb,
                          input logic [31:0] so_ref, input bit chk_so);
    for (int k = 0; k < 32; k++) begin
      chk("q_stable_in_shift", io_q, qb);
      chk("busy_in_shift", {31'd0, io_busy}, 32'd1);
      if (chk_so) chk("scan_out_replay", {31'd0, io_scan_out}, {31'd0, so_ref[31-k]});
      io_scan_in = d[31-k];
      @(negedge io_clk);
    end
    chk("q_after_update", io_q, d);
    chk("busy_in_update", {31'd0, io_busy}, 32'd1);
    chk("done_not_early", {31'd0, io_done}, 32'd0);
  endtask

  // From the UPDATE negedge: checks the DONE cycle and the following IDLE cycle.
  task automatic finish_load(input logic [31:0] exp_q, input logic exp_so);
    @(negedge io_clk);
    chk("done_pulse", {31'd0, io_done}, 32'd1);
    chk("busy_in_done", {31'd0, io_busy}, 32'd0);
    chk("q_in_done", io_q, exp_q);
    chk("scan_out_msb", {31'd0, io_scan_out}, {31'd0, exp_so});
    @(negedge io_clk);
    chk("done_one_cycle", {31'd0, io_done}, 32'd0);
    chk("busy_idle", {31'd0, io_busy}, 32'd0);
    chk("q_holds", io_q, exp_q);
  endtask

  initial begin
    vecs[0] = '{d: 32'hA5C3_0F81, exp_q: 32'hA5C3_0F81, exp_so: 1'b1};
    vecs[1] = '{d: 32'hAAAA_AAAA, exp_q: 32'hAAAA_AAAA, exp_so: 1'b1};
    vecs[2] = '{d: 32'h5555_5555, exp_q: 32'h5555_5555, exp_so: 1'b0};
    vecs[3] = '{d: 32'hFFFF_FFFF, exp_q: 32'hFFFF_FFFF, exp_so: 1'b1};
    vecs[4] = '{d: 32'h0000_0001, exp_q: 32'h0000_0001, exp_so: 1'b0};

    io_reset   = 1'b1;
    io_start   = 1'b0;
    io_abort   = 1'b0;
    io_scan_in = 1'b0;
    #1;
    chk("reset_q", io_q, 32'h0);
    chk("reset_busy", {31'd0, io_busy}, 32'd0);
    chk("reset_done", {31'd0, io_done}, 32'd0);
    chk("reset_scan_out", {31'd0, io_scan_out}, 32'd0);
    @(negedge io_clk);
    @(negedge io_clk);
    io_reset = 1'b0;
    @(negedge io_clk);
    model_q = 32'h0;

    // Full loads: each starts from a shift register holding the previous load.
    for (int v = 0; v < 5; v++) begin
      begin_load();
      shift_in(vecs[v].d, model_q, model_q, 1'b1);
      finish_load(vecs[v].exp_q, vecs[v].exp_so);
      model_q = vecs[v].exp_q;
    end

    // Abort after 10 bits.
    begin_load();
    for (int k = 0; k < 10; k++) begin
      chk("q_stable_pre_abort", io_q, model_q);
      io_scan_in = ~io_scan_in;
      @(negedge io_clk);
    end
    io_abort = 1'b1;
    @(negedge io_clk);
    io_abort = 1'b0;
    chk("abort_busy_low", {31'd0, io_busy}, 32'd0);
    chk("abort_q_kept", io_q, model_q);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", {31'd0, io_done}, 32'd0);
      @(negedge io_clk);
    end
    chk("abort_q_still_kept", io_q, model_q);

    // Abort coinciding with the last bit must win over the update.
    begin_load();
    for (int k = 0; k < 31; k++) begin
      io_scan_in = k[0];
      @(negedge io_clk);
    end
    io_abort   = 1'b1;
    io_scan_in = 1'b1;
    @(negedge io_clk);
    io_abort = 1'b0;
    chk("abort_last_busy_low", {31'd0, io_busy}, 32'd0);
    @(negedge io_clk);
    chk("abort_last_no_done", {31'd0, io_done}, 32'd0);
    chk("abort_last_q_kept", io_q, model_q);

    // Start held high across two loads: one restart only once back in IDLE.
    io_start = 1'b1;
    @(negedge io_clk);
    shift_in(32'h1234_5678, model_q, model_q, CAP);
    finish_load(32'h1234_5678, 1'b0);
    @(negedge io_clk);
    shift_in(32'h9ABC_DEF0, 32'h1234_5678, 32'h1234_5678, 1'b1);
    io_start = 1'b0;
    finish_load(32'h9ABC_DEF0, 1'b1);
    model_q = 32'h9ABC_DEF0;

    // Reset raised mid-SHIFT, between clock edges.
    begin_load();
    for (int k = 0; k < 5; k++) begin
      io_scan_in = 1'b1;
      @(negedge io_clk);
    end
    #2;
    io_reset = 1'b1;
    #1;
    chk("rst_shift_q_async", io_q, 32'h0);
    chk("rst_shift_busy", {31'd0, io_busy}, 32'd0);
    @(negedge io_clk);
    io_reset = 1'b0;
    @(negedge io_clk);
    model_q = 32'h0;

    // Reset raised while the latches are transparent.
    begin_load();
    shift_in(32'hC0DE_BEEF, 32'h0, 32'h0, 1'b1);
    #1;
    io_reset = 1'b1;
    #1;
    chk("rst_update_q_async", io_q, 32'h0);
    @(negedge io_clk);
    io_reset = 1'b0;
    @(negedge io_clk);
    chk("rst_update_no_done", {31'd0, io_done}, 32'd0);
    chk("rst_update_q_zero", io_q, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
